// File: rtl/line_refill_unit.sv
// line_refill_unit: producer side of the fetch line buffer.
// Holds the current I-cache line (data, line-aligned PC, valid) and the
// address of the last issued line request (prev_pc_o). On a miss it issues
// one request to the I-cache, captures the response, and drops any
// response that belongs to a request overtaken by a flush. At most one
// request is outstanding.
//
// Optional build macro: LRU_PERF_CNT_EN enables the request/drop counters.
// Without it, req_cnt_o and drop_cnt_o read as zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding, a new miss may be accepted
// REQ     | request presented to the I-cache, waiting for req_ready_i
// WAIT    | request accepted, response will be written into the line
// DISCARD | request accepted but flushed, response will be thrown away

module line_refill_unit #(
    parameter int XLEN     = 32,
    parameter int LINE_OFS = 4,
    parameter int LINE_W   = 8 << LINE_OFS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              pc_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              here_i,
    input  logic              will_be_here_i,
    output logic [XLEN-1:0]   line_pc_o,
    output logic              line_valid_o,
    output logic [LINE_W-1:0] line_data_o,
    output logic [XLEN-1:0]   prev_pc_o,
    output logic              busy_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [XLEN-1:0]   req_addr_o,
    input  logic              resp_valid_i,
    input  logic [LINE_W-1:0] resp_data_i,
    output logic [31:0]       req_cnt_o,
    output logic [31:0]       drop_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              drop_q, drop_d;
    logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
    logic [XLEN-1:0]   line_pc_q, line_pc_d;
    logic              line_valid_q, line_valid_d;
    logic [LINE_W-1:0] line_data_q, line_data_d;

    logic [XLEN-1:0]   pc_line;
    logic              busy;
    logic              miss;
    logic              req_accept;
    logic              resp_drop;

    assign pc_line    = {pc_i[XLEN-1:LINE_OFS], {LINE_OFS{1'b0}}};
    assign busy       = (state_q != S_IDLE);
    assign miss       = pc_valid_i & ~here_i & ~(will_be_here_i & busy) & ~flush_i;
    assign req_accept = (state_q == S_REQ) & req_ready_i;

    // State and line registers; reset clears everything, including any
    // knowledge of an in-flight request (the I-cache resets alongside).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            drop_q       <= 1'b0;
            prev_pc_q    <= '0;
            line_pc_q    <= '0;
            line_valid_q <= 1'b0;
            line_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            prev_pc_q    <= prev_pc_d;
            line_pc_q    <= line_pc_d;
            line_valid_q <= line_valid_d;
            line_data_q  <= line_data_d;
        end
    end

    // Next-state logic; the old line stays readable until a response lands.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        prev_pc_d    = prev_pc_q;
        line_pc_d    = line_pc_q;
        line_valid_d = line_valid_q;
        line_data_d  = line_data_q;
        resp_drop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    prev_pc_d = pc_line;
                    drop_d    = 1'b0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // The request is never withdrawn; a flush only marks its
                // response as unwanted.
                if (req_ready_i) begin
                    state_d = (flush_i | drop_q) ? S_DISCARD : S_WAIT;
                    drop_d  = 1'b0;
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    resp_drop = resp_valid_i;
                    state_d   = resp_valid_i ? S_IDLE : S_DISCARD;
                end else if (resp_valid_i) begin
                    line_data_d  = resp_data_i;
                    line_pc_d    = prev_pc_q;
                    line_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (resp_valid_i) begin
                    resp_drop = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            line_valid_d = 1'b0;
        end
    end

`ifdef LRU_PERF_CNT_EN
    logic [31:0] req_cnt_q;
    logic [31:0] drop_cnt_q;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^pc_i[LINE_OFS-1:0];

    // Free-running wrap-around counters, deliberately untouched by flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            req_cnt_q  <= req_cnt_q + {31'd0, req_accept};
            drop_cnt_q <= drop_cnt_q + {31'd0, resp_drop};
        end
    end

    assign req_cnt_o  = req_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_bits;

    assign unused_bits = ^{pc_i[LINE_OFS-1:0], req_accept, resp_drop};
    assign req_cnt_o   = '0;
    assign drop_cnt_o  = '0;
`endif

    assign line_pc_o    = line_pc_q;
    assign line_valid_o = line_valid_q;
    assign line_data_o  = line_data_q;
    assign prev_pc_o    = prev_pc_q;
    assign busy_o       = busy;
    assign req_valid_o  = (state_q == S_REQ);
    assign req_addr_o   = prev_pc_q;

    // A response with nothing accepted is an I-cache protocol error; the
    // FSM ignores it.
    a_resp_only_when_expected : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        resp_valid_i |-> (state_q == S_WAIT || state_q == S_DISCARD)
    );

endmodule
